sort_sched: RTL and testbench

- Scheduler in front of the 3-stage pipelined 4x2-bit odd-even sorter.
- Shares one sorter instance between NREQ requesters using a round-robin arbiter. Issues at most one 8-bit word per cycle into the sorter.
- Tracks the requester ID of each issued word through a tag pipeline that matches the sorter latency.
- Stores results in a credit-protected response FIFO, so the sorter, which cannot stall, never overflows the FIFO.

---
 rtl/sort_sched_if.sv | 69 ++++++
 rtl/sort_sched.sv | 192 +++++++++++++++++++
 tb/tb_sort_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_sched_if.sv
// -----------------------------------------------------------------------------
// sort_sched_if
//   Bundle of every non-clock signal of sort_sched: the requester side, the
//   link to the external pipelined sorter, and the response side.
//
//   Handshake semantics (both the request and the response channel):
//     A transfer happens in a cycle where valid and ready are both high.
//     An unaccepted request must hold its data stable until it is granted.
//     req_ready may depend combinationally on req_valid.
//     rsp_valid/rsp_data/rsp_id come straight from registers, so they never
//     depend combinationally on rsp_ready.
//
//   Signals
//     req_valid [NREQ]    per-requester word valid
//     req_data  [8*NREQ]  requester i's word is bits [8i+7:8i]
//     req_ready [NREQ]    one-hot grant
//     srt_rst_n           active-low reset for the sorter
//     srt_in    [8]       word presented to the sorter
//     srt_out   [8]       sorter result, LAT cycles after srt_in
//     rsp_valid           response available
//     rsp_data  [8]       sorted word
//     rsp_id    [IDW]     requester index that issued the word
//     rsp_ready           consumer accepts the response
//
//   Modports
//     master : environment (requesters, sorter, response consumer)
//     slave  : the scheduler
// -----------------------------------------------------------------------------
interface sort_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              srt_rst_n;
   logic [7:0]        srt_in;
   logic [7:0]        srt_out;
   logic              rsp_valid;
   logic [7:0]        rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              rsp_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  srt_rst_n,
      input  srt_in,
      output srt_out,
      input  rsp_valid,
      input  rsp_data,
      input  rsp_id,
      output rsp_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output srt_rst_n,
      output srt_in,
      input  srt_out,
      output rsp_valid,
      output rsp_data,
      output rsp_id,
      input  rsp_ready
   );
endinterface

// File: rtl/sort_sched.sv
// -----------------------------------------------------------------------------
// sort_sched
//   Shares one non-stallable pipelined 4x2-bit sorter among NREQ requesters.
//   A round-robin arbiter issues at most one word per cycle into the sorter,
//   a tag pipe of depth LAT carries the requester ID alongside the word, and
//   the sorted result is pushed into a first-word-fall-through response FIFO.
//   Issue is credit-limited so that every word in flight is guaranteed a FIFO
//   slot when it comes out of the sorter.
//
//   Parameters
//     NREQ       number of requesters (2..8)
//     LAT        sorter pipeline latency in clocks
//     FIFO_DEPTH response FIFO entries (>= LAT+1 for full throughput)
//     IDW        requester-ID width (>= clog2(NREQ))
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous reset, active-high
//     bus        sort_sched_if.slave (requests, sorter link, responses)
//     sort_err   (SORT_SCHED_CHECK_EN only) sticky: a pushed word was not
//                descending ([1:0] >= [3:2] >= [5:4] >= [7:6])
//     err_id     (SORT_SCHED_CHECK_EN only) ID of the first failing word
//
//   Build option
//     SORT_SCHED_CHECK_EN  adds the sort_err/err_id output check.
// -----------------------------------------------------------------------------
module sort_sched #(
   parameter int NREQ       = 4,
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = 2
) (
   input  logic         clk,
   input  logic         rst,
   sort_sched_if.slave  bus
`ifdef SORT_SCHED_CHECK_EN
   ,
   output logic           sort_err,
   output logic [IDW-1:0] err_id
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [IDW-1:0] rr_ptr;                  // first requester to consider
   logic [LAT-1:0] tag_v;                   // index 0 is stage 1
   logic [IDW-1:0] tag_id [LAT];
   logic [7:0]     fifo_data [FIFO_DEPTH];
   logic [IDW-1:0] fifo_id   [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   // ---------------------------------------------------------------------
   // Combinational
   // ---------------------------------------------------------------------
   int             inflight;
   logic           credit_ok;
   logic           found;
   logic [IDW-1:0] gnt_idx;
   logic           grant;
   logic           fifo_nonempty;
   logic           push;
   logic           pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign fifo_nonempty = (count != '0);
   assign pop           = fifo_nonempty & bus.rsp_ready;
   assign push          = tag_v[LAT-1];

   // Every word in the tag pipe or the FIFO already owns a FIFO slot. A pop
   // in this cycle frees one slot that the word granted now may claim.
   always_comb begin
      inflight  = $countones(tag_v);
      credit_ok = (inflight + int'(count) - int'(pop)) < FIFO_DEPTH;
   end

   // Round-robin search: the valid requester with the smallest wrapped
   // distance from rr_ptr wins.
   always_comb begin
      int best_d;
      int d;
      found   = 1'b0;
      gnt_idx = '0;
      best_d  = NREQ;
      d       = 0;
      for (int j = 0; j < NREQ; j++) begin
         d = (j + NREQ - int'(rr_ptr)) % NREQ;
         if (bus.req_valid[j] && (d < best_d)) begin
            best_d  = d;
            gnt_idx = IDW'(j);
            found   = 1'b1;
         end
      end
   end

   assign grant = found & credit_ok & ~rst;

   // One-hot grant and the issue mux; a cycle without a grant sends 8'h00.
   always_comb begin
      bus.req_ready = '0;
      bus.srt_in    = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (grant && (gnt_idx == IDW'(i))) begin
            bus.req_ready[i] = 1'b1;
            bus.srt_in       = bus.req_data[8*i +: 8];
         end
      end
   end

   assign bus.srt_rst_n = ~rst;

   // Response side reads the FIFO head; forced to zero while in reset.
   always_comb begin
      bus.rsp_valid = fifo_nonempty & ~rst;
      bus.rsp_data  = rst ? 8'h00 : fifo_data[rd_ptr];
      bus.rsp_id    = rst ? '0    : fifo_id[rd_ptr];
   end

   // ---------------------------------------------------------------------
   // Arbiter pointer, tag pipe, FIFO control
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
         tag_v  <= '0;
         for (int i = 0; i < LAT; i++) tag_id[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (grant) begin
            rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
         end

         // The tag pipe shifts every cycle because the sorter cannot stall.
         tag_v[0]  <= grant;
         tag_id[0] <= gnt_idx;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end

         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);

         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage needs no reset: nothing is read unless count says so.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_data[wr_ptr] <= bus.srt_out;
         fifo_id[wr_ptr]   <= tag_id[LAT-1];
      end
   end

`ifdef SORT_SCHED_CHECK_EN
   // ---------------------------------------------------------------------
   // Output ordering check on every pushed word
   // ---------------------------------------------------------------------
   logic sorted_ok;

   assign sorted_ok = (bus.srt_out[1:0] >= bus.srt_out[3:2]) &&
                      (bus.srt_out[3:2] >= bus.srt_out[5:4]) &&
                      (bus.srt_out[5:4] >= bus.srt_out[7:6]);

   // err_id is captured only on the first failure; later ones leave it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sort_err <= 1'b0;
         err_id   <= '0;
      end else if (push && !sorted_ok && !sort_err) begin
         sort_err <= 1'b1;
         err_id   <= tag_id[LAT-1];
      end
   end
`endif

endmodule

// File: tb/tb_sort_sched.sv
// -----------------------------------------------------------------------------
// tb_sort_sched
//   Bench for sort_sched. Provides a behavioural LAT-deep sorter, directed
//   scenarios with literal expectations, a randomized phase, and a per-cycle
//   comparison against a queue-based model of the scheduler's rules.
// -----------------------------------------------------------------------------
module tb_sort_sched;
   localparam int NREQ       = 4;
   localparam int LAT        = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int IDW        = 2;
   localparam int EW         = 8 + IDW;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sort_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

`ifdef SORT_SCHED_CHECK_EN
   logic           sort_err;
   logic [IDW-1:0] err_id;
`endif

   sort_sched #(
      .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef SORT_SCHED_CHECK_EN
      ,
      .sort_err(sort_err),
      .err_id(err_id)
`endif
   );

   // ---------------------------------------------------------------------
   // Behavioural sorter: fields sorted descending from [1:0] upward
   // ---------------------------------------------------------------------
   function automatic logic [7:0] sort_word(input logic [7:0] w);
      int f[4];
      int t;
      for (int i = 0; i < 4; i++) f[i] = int'(w[2*i +: 2]);
      for (int a = 0; a < 3; a++)
         for (int b = 0; b < 3 - a; b++)
            if (f[b] < f[b+1]) begin
               t = f[b]; f[b] = f[b+1]; f[b+1] = t;
            end
      return {2'(f[3]), 2'(f[2]), 2'(f[1]), 2'(f[0])};
   endfunction

   logic       bad_mode = 1'b0;   // corrupt words granted to requester 1
   logic [7:0] srt_pipe [LAT];

   always @(posedge clk) begin
      if (!bus.srt_rst_n) begin
         for (int i = 0; i < LAT; i++) srt_pipe[i] <= 8'h00;
      end else begin
         srt_pipe[0] <= (bad_mode && bus.req_ready[1]) ? 8'hC0 : sort_word(bus.srt_in);
         for (int i = 1; i < LAT; i++) srt_pipe[i] <= srt_pipe[i-1];
      end
   end

   assign bus.srt_out = srt_pipe[LAT-1];

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: accepted, not yet consumed words, in issue order, with the
   // first cycle each may appear at the response port.
   logic [EW-1:0]   exp_q[$];
   int              exp_rdy_q[$];
   int              rr_m = 0;
   logic [NREQ-1:0] acc_mask = '0;
   int              acc_total = 0;
   int              pop_total = 0;
   int              max_occ = 0;
   int              gnt_log[$];
   int              pop_id_log[$];
   int              pop_cyc_log[$];

   always @(negedge clk) begin
      logic [NREQ-1:0] e_ready;
      logic [7:0]      e_srt;
      logic [7:0]      e_data;
      int              g;
      bit              e_rv;
      bit              m_pop;
      if (rst) begin
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_srt_in",    32'(bus.srt_in),    32'd0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
         chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
         chk("rst_srt_rst_n", 32'(bus.srt_rst_n), 32'd0);
         exp_q.delete();
         exp_rdy_q.delete();
         rr_m     = 0;
         acc_mask = '0;
      end else begin
         e_rv = (exp_q.size() > 0) && (exp_rdy_q[0] <= cyc);
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
         if (e_rv) begin
            chk("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0][EW-1:IDW]));
            chk("rsp_id",   32'(bus.rsp_id),   32'(exp_q[0][IDW-1:0]));
         end
         m_pop = e_rv && bus.rsp_ready;

         // Grant rule: credit available, first valid requester from rr_m.
         e_ready = '0;
         e_srt   = 8'h00;
         g       = -1;
         if ((exp_q.size() - int'(m_pop)) < FIFO_DEPTH) begin
            for (int k = 0; k < NREQ; k++)
               if (g < 0 && bus.req_valid[(rr_m + k) % NREQ]) g = (rr_m + k) % NREQ;
         end
         if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_srt      = bus.req_data[8*g +: 8];
         end
         chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
         chk("srt_in",    32'(bus.srt_in),    32'(e_srt));
         chk("srt_rst_n", 32'(bus.srt_rst_n), 32'd1);

         if (m_pop) begin
            void'(exp_q.pop_front());
            void'(exp_rdy_q.pop_front());
         end
         if (g >= 0) begin
            e_data = (bad_mode && g == 1) ? 8'hC0 : sort_word(e_srt);
            exp_q.push_back({e_data, IDW'(g)});
            exp_rdy_q.push_back(cyc + LAT + 1);
            rr_m = (g + 1) % NREQ;
         end

         // Observed traffic, for the directed expectations.
         if (bus.rsp_valid && bus.rsp_ready) begin
            pop_total++;
            pop_id_log.push_back(int'(bus.rsp_id));
            pop_cyc_log.push_back(cyc);
         end
         acc_mask = bus.req_ready & bus.req_valid;
         for (int i = 0; i < NREQ; i++)
            if (acc_mask[i]) begin
               acc_total++;
               gnt_log.push_back(i);
            end
         if (acc_total - pop_total > max_occ) max_occ = acc_total - pop_total;
      end
   end

   // ---------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // New word only for a requester that is idle or was just accepted.
   task automatic drive_random(input int vpct, input int rpct);
      for (int i = 0; i < NREQ; i++)
         if (!bus.req_valid[i] || acc_mask[i]) begin
            bus.req_valid[i]        = ($urandom_range(99) < vpct);
            bus.req_data[8*i +: 8]  = 8'($urandom);
         end
      bus.rsp_ready = ($urandom_range(99) < rpct);
   endtask

   task automatic idle(input logic ready);
      bus.req_valid = '0;
      bus.rsp_ready = ready;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int a0;
      int p0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.rsp_ready = 1'b0;
      rst           = 1'b1;
      step(3);
      rst = 1'b0;

      // Single word from requester 0.
      bus.req_valid     = 4'b0001;
      bus.req_data[7:0] = 8'b00_01_10_11;
      bus.rsp_ready     = 1'b1;
      #1;
      chk("t1_grant", 32'(bus.req_ready), 32'b0001);
      step(1);
      bus.req_valid = '0;
      step(2);
      chk("t1_not_early", 32'(bus.rsp_valid), 32'd0);
      step(1);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("t1_rsp_data",  32'(bus.rsp_data),  32'b00_01_10_11);
      chk("t1_rsp_id",    32'(bus.rsp_id),    32'd0);
      step(3);

      // All requesters valid continuously from a fresh reset.
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      gnt_log.delete();
      pop_id_log.delete();
      pop_cyc_log.delete();
      for (int c = 0; c < 16; c++) begin
         drive_random(100, 100);
         step(1);
      end
      idle(1'b1);
      step(8);
      chk("p2_grants_n", 32'(gnt_log.size() >= 8), 32'd1);
      chk("p2_pops_n",   32'(pop_id_log.size() >= 8), 32'd1);
      for (int k = 0; k < 8; k++) begin
         chk("p2_grant_order", 32'(gnt_log[k]),    32'(k % 4));
         chk("p2_rsp_order",   32'(pop_id_log[k]), 32'(k % 4));
      end
      for (int k = 0; k < 7; k++)
         chk("p2_back_to_back", 32'(pop_cyc_log[k+1] - pop_cyc_log[k]), 32'd1);

      // Consumer stalled, requester 2 alone: four credits, then stop.
      bus.rsp_ready          = 1'b0;
      bus.req_valid          = 4'b0100;
      bus.req_data[23:16]    = 8'h9C;
      a0 = acc_total;
      step(12);
      chk("p3_accepts", 32'(acc_total - a0), 32'd4);
      chk("p3_stalled", 32'(bus.req_ready), 32'd0);
      pop_id_log.delete();
      a0 = acc_total;
      bus.rsp_ready = 1'b1;
      step(8);
      chk("p3_pops_n", 32'(pop_id_log.size() >= 4), 32'd1);
      for (int k = 0; k < 4; k++) chk("p3_rsp_id", 32'(pop_id_log[k]), 32'd2);
      chk("p3_resumed", 32'(acc_total > a0), 32'd1);

      // Full FIFO: a one-cycle pop lets exactly one more word in.
      bus.rsp_ready = 1'b0;
      max_occ = 0;
      step(10);
      a0 = acc_total;
      bus.rsp_ready = 1'b1;
      step(1);
      bus.rsp_ready = 1'b0;
      step(8);
      chk("p4_one_grant", 32'(acc_total - a0), 32'd1);
      chk("p4_max_occ",   32'(max_occ <= 4), 32'd1);

      // Reset with words in flight.
      idle(1'b1);
      step(10);
      p0 = pop_total;
      bus.req_valid     = 4'b0001;
      bus.req_data[7:0] = 8'h27;
      step(1);
      bus.req_data[7:0] = 8'hE4;
      step(1);
      bus.req_data[7:0] = 8'h5A;
      step(1);
      bus.req_valid = '0;
      step(1);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      bus.req_valid       = 4'b1000;
      bus.req_data[31:24] = 8'h1E;
      #1;
      chk("p5_first_grant", 32'(bus.req_ready), 32'b1000);
      step(1);
      bus.req_valid = '0;
      step(10);
      chk("p5_discarded", 32'(pop_total - p0), 32'd1);

      // Randomized traffic.
      a0 = acc_total;
      p0 = pop_total;
      for (int c = 0; c < 800; c++) begin
         drive_random(60, 70);
         step(1);
      end
      idle(1'b1);
      step(12);
      chk("p6_drained",  32'(exp_q.size()), 32'd0);
      chk("p6_balanced", 32'(acc_total - a0), 32'(pop_total - p0));

`ifdef SORT_SCHED_CHECK_EN
      // Unsorted word from requester 1 trips the sticky check.
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("ck_reset", 32'(sort_err), 32'd0);
      bad_mode          = 1'b1;
      bus.req_valid     = 4'b0010;
      bus.req_data[15:8] = 8'h0F;
      step(1);
      bus.req_valid = '0;
      step(2);
      chk("ck_before_push", 32'(sort_err), 32'd0);
      step(1);
      chk("ck_set",    32'(sort_err), 32'd1);
      chk("ck_err_id", 32'(err_id),   32'd1);
      bus.req_valid       = 4'b1000;
      bus.req_data[31:24] = 8'h1B;
      step(1);
      bus.req_valid = '0;
      step(8);
      chk("ck_sticky",    32'(sort_err), 32'd1);
      chk("ck_id_sticky", 32'(err_id),   32'd1);
      bad_mode = 1'b0;
      rst = 1'b1;
      step(1);
      chk("ck_cleared", 32'(sort_err), 32'd0);
      rst = 1'b0;
      step(2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Backstop so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
